// File: rtl/seq_detector_if.sv
// Bus bundle for seq_detector: stream input, configuration load, counter
// control and the match/status outputs. clk and rst stay outside.
interface seq_detector_if #(
    parameter int unsigned MAX_LEN = 16,
    parameter int unsigned CNT_W   = 8
);
    localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);

    logic               en;
    logic               stream_valid;
    logic               Stream;
    logic               cfg_wr;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               cfg_sat;
    logic               count_clr;
    logic               Tone;
    logic [CNT_W-1:0]   Count;
    logic               count_ovf;
    logic               armed;

    // Producer of the stream and configuration
    modport master (
        output en, stream_valid, Stream, cfg_wr, cfg_pattern, cfg_len,
               cfg_overlap, cfg_sat, count_clr,
        input  Tone, Count, count_ovf, armed
    );

    // The detector itself
    modport slave (
        input  en, stream_valid, Stream, cfg_wr, cfg_pattern, cfg_len,
               cfg_overlap, cfg_sat, count_clr,
        output Tone, Count, count_ovf, armed
    );
endinterface

// File: rtl/seq_detector.sv
// Serial pattern detector with runtime-loadable pattern/length, overlapping
// or non-overlapping matching, a one-cycle Tone pulse per match and a
// wrapping/saturating match counter with sticky overflow.
module seq_detector #(
    parameter int unsigned        MAX_LEN     = 16,
    parameter int unsigned        CNT_W       = 8,
    parameter logic [MAX_LEN-1:0] RST_PATTERN = MAX_LEN'('b101001),
    parameter int unsigned        RST_LEN     = 6,
    parameter bit                 RST_OVERLAP = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    seq_detector_if.slave bus
);
    localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        ARMED = 2'd2
    } state_t;

    state_t             state;
    logic [MAX_LEN-1:0] pattern;
    logic [MAX_LEN-1:0] hist;
    logic [LEN_W-1:0]   len;
    logic [LEN_W-1:0]   fill;
    logic               overlap;
    logic               hit;
    logic               tone;
    logic [CNT_W-1:0]   count;
    logic               ovf;

    logic               accept;
    logic [MAX_LEN-1:0] hist_shift;
    logic [MAX_LEN:0]   len_one;
    logic [MAX_LEN-1:0] len_mask;
    logic [LEN_W:0]     fill_inc;
    logic [LEN_W-1:0]   fill_sat;
    logic [LEN_W-1:0]   cfg_len_clamped;
    logic               match;

    // Bit acceptance, shifted history, length mask and match decision
    always_comb begin
        accept          = bus.en & bus.stream_valid & ~bus.cfg_wr;
        hist_shift      = {hist[MAX_LEN-2:0], bus.Stream};
        len_one         = (MAX_LEN + 1)'(1) << len;
        len_mask        = MAX_LEN'(len_one - (MAX_LEN + 1)'(1));
        fill_inc        = (LEN_W + 1)'(fill) + (LEN_W + 1)'(1);
        fill_sat        = (fill_inc > (LEN_W + 1)'(MAX_LEN)) ? LEN_W'(MAX_LEN)
                                                             : LEN_W'(fill_inc);
        match           = accept && (fill_inc >= (LEN_W + 1)'(len)) &&
                          (((hist_shift ^ pattern) & len_mask) == '0);
        cfg_len_clamped = bus.cfg_len;
        if (bus.cfg_len == '0) begin
            cfg_len_clamped = LEN_W'(1);
        end else if (bus.cfg_len > LEN_W'(MAX_LEN)) begin
            cfg_len_clamped = LEN_W'(MAX_LEN);
        end
    end

    // Detector state machine: configuration, history shift and fill tracking
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            pattern <= RST_PATTERN;
            len     <= LEN_W'(RST_LEN);
            overlap <= RST_OVERLAP;
            hist    <= '0;
            fill    <= '0;
            hit     <= 1'b0;
        end else begin
            // Match is held one cycle so Tone/Count land on the following edge
            hit <= match;
            if (bus.cfg_wr) begin
                pattern <= bus.cfg_pattern;
                len     <= cfg_len_clamped;
                overlap <= bus.cfg_overlap;
            end
            if (!bus.en) begin
                state <= IDLE;
                hist  <= '0;
                fill  <= '0;
            end else if (bus.cfg_wr) begin
                state <= FILL;
                hist  <= '0;
                fill  <= '0;
            end else if (match && !overlap) begin
                // Consumed bits may not seed the next match
                state <= FILL;
                hist  <= hist_shift;
                fill  <= '0;
            end else if (accept) begin
                hist  <= hist_shift;
                fill  <= fill_sat;
                state <= (fill_sat >= len) ? ARMED : FILL;
            end else if (state == IDLE) begin
                state <= FILL;
            end
        end
    end

    // Match counter with wrap/saturate selection and sticky overflow
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tone  <= 1'b0;
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            tone <= hit;
            if (hit) begin
                if (bus.count_clr) begin
                    count <= CNT_W'(1);
                    ovf   <= 1'b0;
                end else if (&count) begin
                    ovf <= 1'b1;
                    if (!bus.cfg_sat) begin
                        count <= '0;
                    end
                end else begin
                    count <= count + CNT_W'(1);
                end
            end else if (bus.count_clr) begin
                count <= '0;
                ovf   <= 1'b0;
            end
        end
    end

    assign bus.Tone      = tone;
    assign bus.Count     = count;
    assign bus.count_ovf = ovf;
    assign bus.armed     = (state == ARMED);
endmodule

// File: tb/tb_seq_detector.sv
// Bench for seq_detector: two instances (8-bit and 2-bit counters) share one
// stimulus; a queue-based reference model is compared on every cycle, plus
// literal expectations from directed scenarios and a randomized phase.
`timescale 1ns/1ps
module tb_seq_detector;
    localparam int unsigned MAX_LEN = 16;
    localparam int unsigned LEN_W   = 5;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic               d_en = 1'b0;
    logic               d_valid = 1'b0;
    logic               d_stream = 1'b0;
    logic               d_cfg_wr = 1'b0;
    logic [MAX_LEN-1:0] d_pat = '0;
    logic [LEN_W-1:0]   d_len = '0;
    logic               d_ovl = 1'b0;
    logic               d_sat = 1'b0;
    logic               d_clr = 1'b0;

    int total = 0;
    int bad   = 0;

    seq_detector_if #(.MAX_LEN(MAX_LEN), .CNT_W(8)) ifa ();
    seq_detector_if #(.MAX_LEN(MAX_LEN), .CNT_W(2)) ifb ();

    assign ifa.en = d_en;           assign ifb.en = d_en;
    assign ifa.stream_valid = d_valid; assign ifb.stream_valid = d_valid;
    assign ifa.Stream = d_stream;   assign ifb.Stream = d_stream;
    assign ifa.cfg_wr = d_cfg_wr;   assign ifb.cfg_wr = d_cfg_wr;
    assign ifa.cfg_pattern = d_pat; assign ifb.cfg_pattern = d_pat;
    assign ifa.cfg_len = d_len;     assign ifb.cfg_len = d_len;
    assign ifa.cfg_overlap = d_ovl; assign ifb.cfg_overlap = d_ovl;
    assign ifa.cfg_sat = d_sat;     assign ifb.cfg_sat = d_sat;
    assign ifa.count_clr = d_clr;   assign ifb.count_clr = d_clr;

    seq_detector #(.MAX_LEN(MAX_LEN), .CNT_W(8)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    seq_detector #(.MAX_LEN(MAX_LEN), .CNT_W(2)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    bit               hq[$];        // bits received since the last flush/consume
    logic [MAX_LEN-1:0] m_pat;
    int               m_len;
    bit               m_ovl;
    bit               pend;         // match found, shows up on the next edge
    bit               e_tone;
    bit               e_armed;
    int               e_cnt[2];
    bit               e_ovf[2];
    int               cmax[2] = '{255, 3};

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pat = MAX_LEN'('b101001);
            m_len = 6;
            m_ovl = 1'b1;
            hq.delete();
            pend = 1'b0;
            e_tone = 1'b0;
            e_armed = 1'b0;
            for (int k = 0; k < 2; k++) begin
                e_cnt[k] = 0;
                e_ovf[k] = 1'b0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (pend) begin
                    if (d_clr) begin
                        e_cnt[k] = 1;
                        e_ovf[k] = 1'b0;
                    end else if (e_cnt[k] == cmax[k]) begin
                        e_ovf[k] = 1'b1;
                        e_cnt[k] = d_sat ? cmax[k] : 0;
                    end else begin
                        e_cnt[k] = e_cnt[k] + 1;
                    end
                end else if (d_clr) begin
                    e_cnt[k] = 0;
                    e_ovf[k] = 1'b0;
                end
            end
            e_tone = pend;
            pend = 1'b0;
            if (d_cfg_wr) begin
                m_pat = d_pat;
                m_ovl = d_ovl;
                m_len = (d_len == 0) ? 1 : (int'(d_len) > MAX_LEN) ? MAX_LEN : int'(d_len);
            end
            if (!d_en || d_cfg_wr) begin
                hq.delete();
            end else if (d_valid) begin
                hq.push_back(d_stream);
                if (hq.size() > MAX_LEN) void'(hq.pop_front());
                if (hq.size() >= m_len) begin
                    pend = 1'b1;
                    for (int i = 0; i < m_len; i++)
                        if (hq[hq.size() - 1 - i] != m_pat[i]) pend = 1'b0;
                end
                if (pend && !m_ovl) hq.delete();
            end
            e_armed = (hq.size() >= m_len);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @%0t: got %0d want %0d", name, $time, act, exp);
        end
    endtask

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (!rst) begin
            chk("tone_a",  32'(ifa.Tone),      32'(e_tone));
            chk("armed_a", 32'(ifa.armed),     32'(e_armed));
            chk("count_a", 32'(ifa.Count),     32'(e_cnt[0]));
            chk("ovf_a",   32'(ifa.count_ovf), 32'(e_ovf[0]));
            chk("tone_b",  32'(ifb.Tone),      32'(e_tone));
            chk("armed_b", 32'(ifb.armed),     32'(e_armed));
            chk("count_b", 32'(ifb.Count),     32'(e_cnt[1]));
            chk("ovf_b",   32'(ifb.count_ovf), 32'(e_ovf[1]));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input logic v, input logic b);
        d_valid = v;
        d_stream = b;
        @(posedge clk);
        #2;
        d_valid = 1'b0;
        d_cfg_wr = 1'b0;
        d_clr = 1'b0;
    endtask

    task automatic cfg(input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] l, input logic o);
        d_cfg_wr = 1'b1;
        d_pat = p;
        d_len = l;
        d_ovl = o;
        step(1'b0, 1'b0);
    endtask

    task automatic clr_step();
        d_clr = 1'b1;
        step(1'b0, 1'b0);
    endtask

    int tones;
    logic [5:0] seq6;
    logic [4:0] seq5;
    int exp_seq[5] = '{1, 2, 3, 0, 1};

    initial begin
        seq6 = 6'b101001;
        seq5 = 5'b10101;
        #1 rst = 1'b1;
        #11;
        chk("rst_tone",  32'(ifa.Tone), 0);
        chk("rst_count", 32'(ifa.Count), 0);
        chk("rst_ovf",   32'(ifa.count_ovf), 0);
        chk("rst_armed", 32'(ifa.armed), 0);
        rst = 1'b0;
        d_en = 1'b1;

        // Reset pattern 101001, back-to-back bits
        for (int i = 5; i >= 0; i--) step(1'b1, seq6[i]);
        chk("d1_armed", 32'(ifa.armed), 1);
        chk("d1_tone_early", 32'(ifa.Tone), 0);
        step(1'b0, 1'b0);
        chk("d1_tone", 32'(ifa.Tone), 1);
        chk("d1_count", 32'(ifa.Count), 1);
        step(1'b0, 1'b0);
        chk("d1_tone_drop", 32'(ifa.Tone), 0);

        // Pattern 101, overlapping
        clr_step();
        cfg(MAX_LEN'('b101), LEN_W'(3), 1'b1);
        tones = 0;
        for (int i = 4; i >= 0; i--) begin step(1'b1, seq5[i]); tones += int'(ifa.Tone); end
        for (int i = 0; i < 2; i++) begin step(1'b0, 1'b0); tones += int'(ifa.Tone); end
        chk("d2_pulses", 32'(tones), 2);
        chk("d2_count", 32'(ifa.Count), 2);

        // Pattern 101, non-overlapping
        clr_step();
        cfg(MAX_LEN'('b101), LEN_W'(3), 1'b0);
        tones = 0;
        for (int i = 4; i >= 0; i--) begin step(1'b1, seq5[i]); tones += int'(ifa.Tone); end
        for (int i = 0; i < 2; i++) begin step(1'b0, 1'b0); tones += int'(ifa.Tone); end
        chk("d3_pulses", 32'(tones), 1);
        chk("d3_count", 32'(ifa.Count), 1);
        chk("d3_armed", 32'(ifa.armed), 0);

        // 2-bit counter: wrap, then saturate, then clear on a match
        clr_step();
        d_sat = 1'b0;
        cfg(MAX_LEN'('b1), LEN_W'(1), 1'b1);
        for (int i = 0; i < 6; i++) begin
            step(i < 5, 1'b1);
            if (i >= 1) chk("d4_wrap_count", 32'(ifb.Count), 32'(exp_seq[i-1]));
        end
        chk("d4_wrap_ovf", 32'(ifb.count_ovf), 1);
        clr_step();
        d_sat = 1'b1;
        for (int i = 0; i < 6; i++) step(i < 5, 1'b1);
        chk("d4_sat_count", 32'(ifb.Count), 3);
        chk("d4_sat_ovf", 32'(ifb.count_ovf), 1);
        step(1'b1, 1'b1);
        d_clr = 1'b1;
        step(1'b0, 1'b0);
        chk("d4_clr_match_count", 32'(ifb.Count), 1);
        chk("d4_clr_match_ovf", 32'(ifb.count_ovf), 0);
        d_sat = 1'b0;

        // Valid gaps inside 101001, then en dropped mid-pattern
        clr_step();
        cfg(MAX_LEN'('b101001), LEN_W'(6), 1'b1);
        for (int i = 5; i >= 0; i--) begin step(1'b1, seq6[i]); step(1'b0, 1'b1); end
        step(1'b0, 1'b0);
        chk("d5_gap_count", 32'(ifa.Count), 1);
        for (int i = 5; i >= 3; i--) step(1'b1, seq6[i]);
        d_en = 1'b0;
        step(1'b1, 1'b0);
        d_en = 1'b1;
        for (int i = 2; i >= 0; i--) step(1'b1, seq6[i]);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        chk("d5_en_drop_count", 32'(ifa.Count), 1);

        // Asynchronous reset mid-pattern restores reset configuration
        cfg(MAX_LEN'('b11), LEN_W'(2), 1'b0);
        for (int i = 5; i >= 3; i--) step(1'b1, seq6[i]);
        #1 rst = 1'b1;
        #1;
        chk("ar_count_a", 32'(ifa.Count), 0);
        chk("ar_count_b", 32'(ifb.Count), 0);
        chk("ar_armed", 32'(ifa.armed), 0);
        chk("ar_tone", 32'(ifa.Tone), 0);
        #2 rst = 1'b0;
        @(posedge clk); #2;
        for (int i = 5; i >= 0; i--) step(1'b1, seq6[i]);
        step(1'b0, 1'b0);
        chk("ar_restored_tone", 32'(ifa.Tone), 1);
        chk("ar_restored_count", 32'(ifa.Count), 1);

        // cfg_len of 0 behaves as length 1
        cfg(MAX_LEN'('b1), LEN_W'(0), 1'b1);
        step(1'b1, 1'b1);
        step(1'b0, 1'b0);
        chk("len0_tone", 32'(ifa.Tone), 1);

        // Randomized phase checked by the model
        for (int n = 0; n < 4000; n++) begin
            int r;
            d_en = ($urandom_range(0, 31) != 0);
            d_clr = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 99) == 0) d_sat = ~d_sat;
            if ($urandom_range(0, 49) == 0) begin
                r = int'($urandom_range(0, 9));
                d_cfg_wr = 1'b1;
                d_pat = MAX_LEN'($urandom);
                d_ovl = 1'($urandom);
                d_len = (r == 0) ? LEN_W'(0) :
                        (r == 9) ? LEN_W'($urandom_range(14, 31)) :
                                   LEN_W'($urandom_range(1, 4));
            end
            step($urandom_range(0, 3) != 0, 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/seq_detector.md
# seq_detector

Parametrised serial bit-pattern detector. It is the next generation of the fixed 101001 stream FSM. It samples a qualified bitstream on `clk` and compares it against a runtime-loadable pattern of programmable length, from 1 to MAX_LEN bits. It supports overlapping and non-overlapping detection, a one-cycle `Tone` pulse per match, and a wrapping or saturating match counter with a sticky overflow flag. It sits between the serial front end and the status/interrupt logic.

## Interface
- MAX_LEN, 16: maximum pattern length in bits, 2..32.
- CNT_W, 8: width of `Count`, 1..32.
- RST_PATTERN, 'b101001: pattern loaded at reset, right-aligned.
- RST_LEN, 6: pattern length loaded at reset.
- RST_OVERLAP, 1: overlap mode loaded at reset.
- clk  in  1  single clock; all logic is rising-edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  detector enable.
- stream_valid  in  1  `Stream` carries a valid bit this cycle.
- Stream  in  1  serial data bit.
- cfg_wr  in  1  one-cycle configuration load strobe.
- cfg_pattern  in  MAX_LEN  new pattern, right-aligned.
- cfg_len  in  $clog2(MAX_LEN+1)  new pattern length.
- cfg_overlap  in  1  1 = overlapping detection, 0 = non-overlapping.
- cfg_sat  in  1  1 = `Count` saturates, 0 = `Count` wraps; live input, not latched.
- count_clr  in  1  synchronous clear of `Count` and `count_ovf`.
- Tone  out  1  registered one-cycle pulse per detected match.
- Count  out  CNT_W  number of matches detected.
- count_ovf  out  1  sticky overflow flag.
- armed  out  1  detector holds at least `len` bits of history.

## Operation
- A bit is accepted when `en & stream_valid & ~cfg_wr`.
- Bit order: the first-received bit of the pattern is `pattern[len-1]`; the last is `pattern[0]`.
- On each accepted bit: `hist <= {hist[MAX_LEN-2:0], Stream}` and `fill <= min(fill+1, MAX_LEN)`.
- Match condition, evaluated on the shifted value including the current bit: `fill+1 >= len` and the low `len` bits of the new `hist` equal the low `len` bits of `pattern`.
- On a match:
  - Overlap mode: `fill` continues counting.
  - Non-overlap mode: `fill <= 0`, so history bits already consumed cannot start the next match.
- `cfg_wr` loads `pattern`, `len` and `overlap`, and sets `hist` and `fill` to 0.
  - `cfg_len` of 0 is clamped to 1; values above MAX_LEN are clamped to MAX_LEN.
  - A bit presented in the same cycle as `cfg_wr` is dropped.
  - `Count` and `count_ovf` are not affected.
- State machine (encoded state register):
  - IDLE, entered when `en=0`: no bits are accepted; `hist` and `fill` are flushed to 0. IDLE→FILL when `en=1`.
  - FILL, `fill < len`: accepts bits. FILL→ARMED when `fill` reaches `len` without a non-overlap match. A non-overlap match returns or stays in FILL.
  - ARMED, `fill >= len`: accepts bits. ARMED→FILL on a non-overlap match or on `cfg_wr`.
  - From any state: `en=0` → IDLE; `cfg_wr` with `en=1` → FILL.
- `armed` = (state == ARMED).
- Counter:
  - Each match increments `Count`.
  - At all-ones: `cfg_sat=1` holds the value, `cfg_sat=0` wraps to 0. Either case sets `count_ovf`.
  - `count_clr` alone: `Count <= 0`, `count_ovf <= 0`.
  - `count_clr` together with a match: `Count <= 1`, `count_ovf <= 0`.

## Timing
- Reset values: `Tone=0`, `Count=0`, `count_ovf=0`, `armed=0`, state IDLE, `hist=0`, `fill=0`; `pattern`, `len` and `overlap` take their RST_* values.
- Reset asserts immediately and asynchronously, including mid-pattern. Operation resumes on the first rising edge after deassertion.
- Latency: a completing bit accepted at edge N raises `Tone` and updates `Count` after edge N+1. `Tone` stays high for exactly one cycle unless the next accepted bit also completes a match.
- Back-to-back accepted bits are sustained at one bit per cycle; there is no backpressure.
- `cfg_wr` takes effect at the next edge. The first bit that can match under the new configuration is the one accepted in the following cycle.
- Dropping `en` mid-pattern discards partial history. `Count` and `count_ovf` are kept.

## Test plan
- Reset defaults, stream 1,0,1,0,0,1 with valid every cycle → `Tone` single pulse one cycle after the 6th bit; `Count`=1; `armed`=1.
- `cfg_wr` with pattern 'b101, len 3, overlap 1, then stream 1,0,1,0,1 → two `Tone` pulses (after bits 3 and 5); `Count`=2.
- Same stimulus with overlap 0 → one pulse, after bit 3; `Count`=1; state returns to FILL after the match.
- CNT_W=2, pattern 'b1, len 1: five 1-bits with `cfg_sat=0` → `Count` sequence 1,2,3,0,1 and `count_ovf`=1; repeat with `cfg_sat=1` → `Count` holds at 3, `count_ovf`=1; `count_clr` asserted on a match cycle → `Count`=1, `count_ovf`=0.
- `stream_valid` gaps inside 101001 → still one match. `en` dropped after the 3rd bit and reasserted, then 001 → no match.
- `rst` pulsed mid-pattern and asynchronously → all outputs 0 before the next edge, RST_* configuration restored. `cfg_len`=0 loads as len 1.
